// File: rtl/matrix_input_module.sv
// Oversampling receiver for the multi-lane SPI stream and the 74HC595-style
// column-select interface; emits per-lane words tagged with the latched column.
module matrix_input_module #(
  parameter int CHANNEL_NUMBER = 3,
  parameter int SPI_SIZE       = 8,
  parameter int MSB_FIRST      = 1,
  parameter int COLUMN_NUMBER  = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              I_clk,
  input  logic                              I_rst_n,
  input  logic                              I_spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]         I_spi_mosi,
  input  logic                              I_ser_clk,
  input  logic                              I_ser_data,
  input  logic                              I_ser_stcp,
  input  logic                              I_ser_n_enable,
  output logic [SPI_SIZE-1:0]               O_data [CHANNEL_NUMBER],
  output logic                              O_data_valid,
  output logic [$clog2(COLUMN_NUMBER)-1:0]  O_data_column,
  output logic [$clog2(COLUMN_NUMBER)-1:0]  O_column,
  output logic                              O_column_valid,
  output logic                              O_column_strobe,
  output logic                              O_extra_bit,
  output logic                              O_frame_error
);

  localparam int COL_W = $clog2(COLUMN_NUMBER);
  localparam int CNT_W = $clog2(SPI_SIZE + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IN_W  = CHANNEL_NUMBER + 5;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_SIZE - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Every input shares one synchroniser chain so lane-to-clock alignment survives.
  logic [IN_W-1:0] raw_in;
  logic [IN_W-1:0] sync_q [SYNC_STAGES];
  logic [IN_W-1:0] synced;

  assign raw_in = {I_ser_n_enable, I_ser_stcp, I_ser_data, I_ser_clk, I_spi_mosi, I_spi_clk};
  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge I_clk or posedge I_rst_n) begin
    if (I_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic                      spi_clk_s, ser_clk_s, ser_data_s, stcp_s, n_enable_s;
  logic [CHANNEL_NUMBER-1:0] mosi_s;
  logic                      spi_clk_d, ser_clk_d, stcp_d;
  logic                      spi_edge, ser_edge, stcp_edge;

  assign spi_clk_s  = synced[0];
  assign mosi_s     = synced[CHANNEL_NUMBER:1];
  assign ser_clk_s  = synced[CHANNEL_NUMBER+1];
  assign ser_data_s = synced[CHANNEL_NUMBER+2];
  assign stcp_s     = synced[CHANNEL_NUMBER+3];
  assign n_enable_s = synced[CHANNEL_NUMBER+4];

  assign spi_edge  = spi_clk_s & ~spi_clk_d;
  assign ser_edge  = ser_clk_s & ~ser_clk_d;
  assign stcp_edge = stcp_s & ~stcp_d;

  always_ff @(posedge I_clk or posedge I_rst_n) begin
    if (I_rst_n) begin
      spi_clk_d <= 1'b0;
      ser_clk_d <= 1'b0;
      stcp_d    <= 1'b0;
    end else begin
      spi_clk_d <= spi_clk_s;
      ser_clk_d <= ser_clk_s;
      stcp_d    <= stcp_s;
    end
  end

  logic [SPI_SIZE-1:0] shreg [CHANNEL_NUMBER];
  logic [CNT_W-1:0]    bit_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                word_done;
  logic [COL_W-1:0]    done_column;

  // The column is captured on the final edge itself, so a coincident stcp
  // edge (which updates O_column in that same cycle) cannot leak into the tag.
  always_ff @(posedge I_clk or posedge I_rst_n) begin
    if (I_rst_n) begin
      for (int c = 0; c < CHANNEL_NUMBER; c++) begin
        shreg[c]  <= '0;
        O_data[c] <= '0;
      end
      bit_cnt       <= '0;
      tmo_cnt       <= '0;
      word_done     <= 1'b0;
      done_column   <= '0;
      O_data_valid  <= 1'b0;
      O_data_column <= '0;
      O_frame_error <= 1'b0;
    end else begin
      word_done     <= 1'b0;
      O_data_valid  <= 1'b0;
      O_frame_error <= 1'b0;
      if (spi_edge) begin
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
          if (MSB_FIRST != 0) shreg[c] <= {shreg[c][SPI_SIZE-2:0], mosi_s[c]};
          else                shreg[c] <= {mosi_s[c], shreg[c][SPI_SIZE-1:1]};
        end
        tmo_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt     <= '0;
          word_done   <= 1'b1;
          done_column <= O_column;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (bit_cnt != '0 && tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (tmo_cnt == TMO_LAST) begin
          bit_cnt       <= '0;
          O_frame_error <= 1'b1;
        end
      end
      if (word_done) begin
        O_data        <= shreg;
        O_data_valid  <= 1'b1;
        O_data_column <= done_column;
      end
    end
  end

  function automatic logic is_onehot(input logic [COLUMN_NUMBER-1:0] v);
    return (v != '0) && ((v & (v - COLUMN_NUMBER'(1))) == '0);
  endfunction

  function automatic logic [COL_W-1:0] onehot_index(input logic [COLUMN_NUMBER-1:0] v);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLUMN_NUMBER; i++) if (v[i]) idx = COL_W'(i);
    return idx;
  endfunction

  logic [COLUMN_NUMBER:0] sr;
  logic [COLUMN_NUMBER:0] storage;

  assign O_extra_bit = storage[COLUMN_NUMBER];

  // Decode straight from sr on a latch so the strobe and new column coincide.
  always_ff @(posedge I_clk or posedge I_rst_n) begin
    if (I_rst_n) begin
      sr              <= '0;
      storage         <= '0;
      O_column        <= '0;
      O_column_valid  <= 1'b0;
      O_column_strobe <= 1'b0;
    end else begin
      O_column_strobe <= stcp_edge;
      if (ser_edge) sr <= {sr[COLUMN_NUMBER-1:0], ser_data_s};
      if (stcp_edge) begin
        storage <= sr;
        if (is_onehot(sr[COLUMN_NUMBER-1:0])) O_column <= onehot_index(sr[COLUMN_NUMBER-1:0]);
      end
      O_column_valid <= is_onehot(stcp_edge ? sr[COLUMN_NUMBER-1:0] : storage[COLUMN_NUMBER-1:0])
                        && !n_enable_s;
    end
  end

endmodule

// File: tb/tb_matrix_input_module.sv
// Directed bench for matrix_input_module: an MSB-first and an LSB-first
// instance share one stimulus; word vectors are table driven.
module tb_matrix_input_module;

  localparam int CH  = 3;
  localparam int SYN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_clk = 1'b0;
  logic [CH-1:0] mosi = '0;
  logic ser_clk = 1'b0, ser_data = 1'b0, stcp = 1'b0, n_enable = 1'b0;

  logic [7:0] data_m [CH];
  logic [7:0] data_l [CH];
  logic       valid_m, valid_l;
  logic [3:0] dcol_m, dcol_l, col_m, col_l;
  logic       cval_m, cval_l, strobe_m, strobe_l, extra_m, extra_l, ferr_m, ferr_l;

  always #5 clk = ~clk;

  matrix_input_module #(.MSB_FIRST(1)) dut_m (
    .I_clk(clk), .I_rst_n(rst), .I_spi_clk(spi_clk), .I_spi_mosi(mosi),
    .I_ser_clk(ser_clk), .I_ser_data(ser_data), .I_ser_stcp(stcp), .I_ser_n_enable(n_enable),
    .O_data(data_m), .O_data_valid(valid_m), .O_data_column(dcol_m), .O_column(col_m),
    .O_column_valid(cval_m), .O_column_strobe(strobe_m), .O_extra_bit(extra_m),
    .O_frame_error(ferr_m));

  matrix_input_module #(.MSB_FIRST(0)) dut_l (
    .I_clk(clk), .I_rst_n(rst), .I_spi_clk(spi_clk), .I_spi_mosi(mosi),
    .I_ser_clk(ser_clk), .I_ser_data(ser_data), .I_ser_stcp(stcp), .I_ser_n_enable(n_enable),
    .O_data(data_l), .O_data_valid(valid_l), .O_data_column(dcol_l), .O_column(col_l),
    .O_column_valid(cval_l), .O_column_strobe(strobe_l), .O_extra_bit(extra_l),
    .O_frame_error(ferr_l));

  int checks = 0, failures = 0;
  int cyc = 0, last_rise = 0, last_valid = 0;
  int nvalid_m = 0, nvalid_l = 0, nferr = 0, nstrobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_m) begin nvalid_m++; last_valid = cyc; end
      if (valid_l) nvalid_l++;
      if (ferr_m) nferr++;
      if (strobe_m) nstrobe++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic [CH-1:0] b, input logic with_stcp);
    @(negedge clk);
    mosi = b;
    wait_clk(2);
    spi_clk = 1'b1;
    last_rise = cyc;
    if (with_stcp) stcp = 1'b1;
    wait_clk(4);
    spi_clk = 1'b0;
    stcp = 1'b0;
    wait_clk(2);
  endtask

  // Lane bytes go out bit 7 first; nbits < 8 leaves a partial word.
  task automatic send_word(input logic [CH-1:0][7:0] w, input int nbits, input logic stcp_last);
    logic [CH-1:0] b;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < CH; c++) b[c] = w[c][7-i];
      spi_bit(b, stcp_last && (i == nbits - 1));
    end
    wait_clk(8);
  endtask

  task automatic ser_shift(input logic d, input logic with_stcp);
    @(negedge clk);
    ser_data = d;
    wait_clk(2);
    ser_clk = 1'b1;
    if (with_stcp) stcp = 1'b1;
    wait_clk(4);
    ser_clk = 1'b0;
    stcp = 1'b0;
    wait_clk(2);
  endtask

  task automatic ser_latch();
    @(negedge clk);
    stcp = 1'b1;
    wait_clk(4);
    stcp = 1'b0;
    wait_clk(6);
  endtask

  typedef struct {
    logic [CH-1:0][7:0] tx;
    logic [CH-1:0][7:0] exp_m;
    logic [CH-1:0][7:0] exp_l;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int v0, s0, f0;
    logic [CH-1:0][7:0] w;

    vecs[0].tx = {8'hFF, 8'h3C, 8'hA5}; vecs[0].exp_m = {8'hFF, 8'h3C, 8'hA5}; vecs[0].exp_l = {8'hFF, 8'h3C, 8'hA5};
    vecs[1].tx = {8'h13, 8'h48, 8'hA5}; vecs[1].exp_m = {8'h13, 8'h48, 8'hA5}; vecs[1].exp_l = {8'hC8, 8'h12, 8'hA5};
    vecs[2].tx = {8'h6E, 8'h80, 8'h01}; vecs[2].exp_m = {8'h6E, 8'h80, 8'h01}; vecs[2].exp_l = {8'h76, 8'h01, 8'h80};
    vecs[3].tx = {8'h96, 8'h0F, 8'hF0}; vecs[3].exp_m = {8'h96, 8'h0F, 8'hF0}; vecs[3].exp_l = {8'h69, 8'hF0, 8'h0F};

    wait_clk(3);
    check("rst_data0", data_m[0], 8'h00);
    check("rst_valid", valid_m, 1'b0);
    check("rst_column", col_m, 4'd0);
    check("rst_cvalid", cval_m, 1'b0);
    check("rst_extra", extra_m, 1'b0);
    check("rst_ferr", ferr_m, 1'b0);
    rst = 1'b0;
    wait_clk(4);

    for (int v = 0; v < 4; v++) begin
      v0 = nvalid_m; s0 = nvalid_l; f0 = nferr;
      send_word(vecs[v].tx, 8, 1'b0);
      if (v == 0) check("valid_latency", last_valid - last_rise, SYN + 2);
      check($sformatf("v%0d_nvalid_m", v), nvalid_m - v0, 1);
      check($sformatf("v%0d_nvalid_l", v), nvalid_l - s0, 1);
      check($sformatf("v%0d_ferr", v), nferr - f0, 0);
      check($sformatf("v%0d_dcol", v), dcol_m, 4'd0);
      for (int c = 0; c < CH; c++) begin
        check($sformatf("v%0d_msb_lane%0d", v, c), data_m[c], vecs[v].exp_m[c]);
        check($sformatf("v%0d_lsb_lane%0d", v, c), data_l[c], vecs[v].exp_l[c]);
      end
    end

    // Column chain: 1 then 16 zeros parks the 1 in the extra bit.
    s0 = nstrobe;
    ser_shift(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) ser_shift(1'b0, 1'b0);
    ser_latch();
    check("extra_strobe", nstrobe - s0, 1);
    check("extra_bit", extra_m, 1'b1);
    check("extra_cvalid", cval_m, 1'b0);
    check("extra_col_hold", col_m, 4'd0);

    ser_shift(1'b1, 1'b0);
    ser_latch();
    check("col0_col", col_m, 4'd0);
    check("col0_cvalid", cval_m, 1'b1);
    check("col0_extra", extra_m, 1'b0);

    for (int i = 0; i < 5; i++) ser_shift(1'b0, 1'b0);
    ser_latch();
    check("col5_col", col_m, 4'd5);
    check("col5_cvalid", cval_m, 1'b1);

    s0 = nstrobe;
    @(negedge clk) n_enable = 1'b1;
    wait_clk(8);
    check("nen_cvalid", cval_m, 1'b0);
    check("nen_col", col_m, 4'd5);
    check("nen_no_strobe", nstrobe - s0, 0);

    @(negedge clk) n_enable = 1'b0;
    wait_clk(8);
    check("nen_low_cvalid", cval_m, 1'b1);

    ser_shift(1'b1, 1'b0);
    ser_latch();
    check("multi_cvalid", cval_m, 1'b0);
    check("multi_col_hold", col_m, 4'd5);

    for (int i = 0; i < 17; i++) ser_shift(1'b0, 1'b0);
    ser_shift(1'b1, 1'b0);
    ser_shift(1'b0, 1'b0);
    ser_latch();
    check("col1_col", col_m, 4'd1);
    ser_shift(1'b0, 1'b0);
    ser_shift(1'b0, 1'b1);
    check("pre_shift_col", col_m, 4'd2);
    check("pre_shift_cvalid", cval_m, 1'b1);

    // Timeout: 3 bits then idle.
    v0 = nvalid_m; f0 = nferr;
    w = {8'hE0, 8'hE0, 8'hE0};
    send_word(w, 3, 1'b0);
    wait_clk(40);
    check("tmo_early", nferr - f0, 0);
    wait_clk(40);
    check("tmo_ferr", nferr - f0, 1);
    check("tmo_no_valid", nvalid_m - v0, 0);
    w = {8'h00, 8'h00, 8'h81};
    send_word(w, 8, 1'b0);
    check("after_tmo_data", data_m[0], 8'h81);
    check("after_tmo_valid", nvalid_m - v0, 1);
    check("after_tmo_ferr", nferr - f0, 1);

    // Final SPI edge coincides with the stcp edge moving column 2 -> 3.
    w = {8'h00, 8'h00, 8'hC3};
    send_word(w, 8, 1'b1);
    check("coinc_data", data_m[0], 8'hC3);
    check("coinc_dcol", dcol_m, 4'd2);
    check("coinc_col", col_m, 4'd3);

    w = {8'hFF, 8'hFF, 8'hFF};
    send_word(w, 4, 1'b0);
    @(negedge clk) rst = 1'b1;
    wait_clk(3);
    check("midrst_data0", data_m[0], 8'h00);
    check("midrst_dcol", dcol_m, 4'd0);
    check("midrst_col", col_m, 4'd0);
    check("midrst_cvalid", cval_m, 1'b0);
    @(negedge clk) rst = 1'b0;
    wait_clk(4);
    v0 = nvalid_m;
    w = {8'h00, 8'h00, 8'h5A};
    send_word(w, 8, 1'b0);
    check("post_rst_data", data_m[0], 8'h5A);
    check("post_rst_valid", nvalid_m - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
